// File: rtl/bnn_controller.sv
// bnn_controller
//   Sequences one binarised-network inference. It assembles the pixel and
//   weight images from 8-bit load beats, then steps the layer blocks through
//   LAYER1..LAYER3 with a per-phase watchdog, and finally latches the class.
//
// Ports
//   clk, rst_n                   clock, asynchronous active-low reset
//   start, abort                 begin inference / force back to IDLE
//   load_valid, load_data        load beat handshake (in)
//   load_ready                   high only in LOAD (out)
//   state                        phase code broadcast to the layer blocks
//   layer_rst_n                  synchronous reset to the layer blocks (high in LAYERx)
//   pixels, weights              assembled image and layer-1 weights
//   l1_done, l2_done, l3_done    layer completion flags
//   result_in, result            layer-3 class output and its latched copy
//   busy, done, error            status flags
module bnn_controller #(
   parameter int unsigned TIMEOUT   = 4096,
   parameter int unsigned BEATS_PIX = 98,
   parameter int unsigned BEATS_WT  = 9
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    start,
   input  logic                    abort,
   input  logic                    load_valid,
   input  logic [7:0]              load_data,
   output logic                    load_ready,
   output logic [2:0]              state,
   output logic                    layer_rst_n,
   output logic [8*BEATS_PIX-1:0]  pixels,
   output logic [8*BEATS_WT-1:0]   weights,
   input  logic                    l1_done,
   input  logic                    l2_done,
   input  logic                    l3_done,
   input  logic [3:0]              result_in,
   output logic [3:0]              result,
   output logic                    busy,
   output logic                    done,
   output logic                    error
);

   localparam int unsigned BEATS = BEATS_PIX + BEATS_WT;
   localparam int unsigned BW    = $clog2(BEATS + 1);
   localparam int unsigned CW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   typedef enum logic [2:0] {
      S_IDLE   = 3'b000,
      S_LOAD   = 3'b001,
      S_LAYER1 = 3'b010,
      S_LAYER2 = 3'b011,
      S_LAYER3 = 3'b100,
      S_DONE   = 3'b101,
      S_ERROR  = 3'b111
   } state_t;

   state_t                  r_state;
   state_t                  w_next;
   logic [1:0]              r_rst_sync;
   logic                    w_rst_n;
   logic [BW-1:0]           r_beat;
   logic [CW-1:0]           r_cyc;
   logic                    w_accept;
   logic                    w_last_beat;
   logic                    w_timeout;
   logic                    w_next_layer;
   logic                    r_load_ready;
   logic                    r_layer_rst_n;
   logic                    r_busy;
   logic                    r_done;
   logic                    r_error;
   logic [8*BEATS_PIX-1:0]  r_pixels;
   logic [8*BEATS_WT-1:0]   r_weights;
   logic [3:0]              r_result;

   // Reset asserts immediately but releases only after two clk edges, so the
   // FSM cannot leave IDLE on a metastable release.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_rst_sync <= '0;
      else        r_rst_sync <= {r_rst_sync[0], 1'b1};
   end
   assign w_rst_n = r_rst_sync[1];

   assign w_accept     = r_load_ready & load_valid;
   assign w_last_beat  = (r_beat == BW'(BEATS - 1));
   assign w_timeout    = (r_cyc == CW'(TIMEOUT - 1));
   assign w_next_layer = (w_next == S_LAYER1) || (w_next == S_LAYER2) || (w_next == S_LAYER3);

   // A done flag is only looked at in its own phase and beats the watchdog.
   always_comb begin
      w_next = r_state;
      if (abort) begin
         w_next = S_IDLE;
      end else begin
         case (r_state)
            S_IDLE, S_DONE, S_ERROR: if (start) w_next = S_LOAD;
            S_LOAD:   if (w_accept && w_last_beat) w_next = S_LAYER1;
            S_LAYER1: if (l1_done) w_next = S_LAYER2; else if (w_timeout) w_next = S_ERROR;
            S_LAYER2: if (l2_done) w_next = S_LAYER3; else if (w_timeout) w_next = S_ERROR;
            S_LAYER3: if (l3_done) w_next = S_DONE;   else if (w_timeout) w_next = S_ERROR;
            default:  w_next = S_IDLE;
         endcase
      end
   end

   // Status outputs are registered from the next state so they always agree
   // with the registered state code.
   always_ff @(posedge clk or negedge w_rst_n) begin
      if (!w_rst_n) begin
         r_state       <= S_IDLE;
         r_load_ready  <= 1'b0;
         r_layer_rst_n <= 1'b0;
         r_busy        <= 1'b0;
         r_done        <= 1'b0;
         r_error       <= 1'b0;
         r_result      <= '0;
         r_beat        <= '0;
         r_cyc         <= '0;
         r_pixels      <= '0;
         r_weights     <= '0;
      end else begin
         r_state       <= w_next;
         r_load_ready  <= (w_next == S_LOAD);
         r_layer_rst_n <= w_next_layer;
         r_busy        <= (w_next == S_LOAD) || w_next_layer;
         r_done        <= (w_next == S_DONE);
         r_error       <= (w_next == S_ERROR);

         if ((r_state == S_LAYER3) && (w_next == S_DONE)) r_result <= result_in;

         if ((w_next == S_LOAD) && (r_state != S_LOAD)) r_beat <= '0;
         else if (w_accept)                             r_beat <= r_beat + BW'(1);

         // Any phase change restarts the watchdog; r_layer_rst_n marks the
         // cycles spent inside a LAYERx phase.
         if (w_next != r_state)  r_cyc <= '0;
         else if (r_layer_rst_n) r_cyc <= r_cyc + CW'(1);

         if (w_accept) begin
            if (r_beat < BW'(BEATS_PIX)) r_pixels[r_beat*8 +: 8] <= load_data;
            else                         r_weights[(r_beat - BW'(BEATS_PIX))*8 +: 8] <= load_data;
         end
      end
   end

   assign state       = r_state;
   assign load_ready  = r_load_ready;
   assign layer_rst_n = r_layer_rst_n;
   assign busy        = r_busy;
   assign done        = r_done;
   assign error       = r_error;
   assign result      = r_result;
   assign pixels      = r_pixels;
   assign weights     = r_weights;

endmodule

// File: tb/tb_bnn_controller.sv
module tb_bnn_controller;

   localparam int TO  = 64;
   localparam int BP  = 98;
   localparam int BWT = 9;
   localparam int NB  = BP + BWT;

   logic            clk = 1'b0;
   logic            rst_n, start, abort, load_valid, load_ready;
   logic [7:0]      load_data;
   logic [2:0]      state;
   logic            layer_rst_n;
   logic [8*BP-1:0] pixels;
   logic [8*BWT-1:0] weights;
   logic            l1_done, l2_done, l3_done;
   logic [3:0]      result_in, result;
   logic            busy, done, error;

   always #5 clk = ~clk;

   bnn_controller #(.TIMEOUT(TO), .BEATS_PIX(BP), .BEATS_WT(BWT)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
      .load_valid(load_valid), .load_data(load_data), .load_ready(load_ready),
      .state(state), .layer_rst_n(layer_rst_n), .pixels(pixels), .weights(weights),
      .l1_done(l1_done), .l2_done(l2_done), .l3_done(l3_done),
      .result_in(result_in), .result(result), .busy(busy), .done(done), .error(error)
   );

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model: phase code, beat count, phase cycle count, byte image.
   int         m_st;
   int         m_beats;
   int         m_cyc;
   logic [7:0] m_img [NB];
   logic [3:0] m_res;

   bit         tracing = 1'b0;
   logic [2:0] trace [$];

   task automatic chk(input string name, input logic [799:0] act, input logic [799:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      m_st = 0; m_beats = 0; m_cyc = 0; m_res = '0;
      for (int i = 0; i < NB; i++) m_img[i] = '0;
   endtask

   task automatic model_step();
      bit       acc   = (m_st == 1) && load_valid;
      bit [2:0] flags = {l3_done, l2_done, l1_done};
      if (acc) begin
         m_img[m_beats] = load_data;
         m_beats++;
      end
      if (abort) m_st = 0;
      else if (m_st == 0 || m_st == 5 || m_st == 7) begin
         if (start) begin m_st = 1; m_beats = 0; m_cyc = 0; end
      end else if (m_st == 1) begin
         if (m_beats == NB) begin m_st = 2; m_cyc = 0; end
      end else begin
         if (flags[m_st-2]) begin
            if (m_st == 4) begin m_res = result_in; m_st = 5; end
            else m_st++;
            m_cyc = 0;
         end else if (m_cyc == TO - 1) m_st = 7;
         else m_cyc++;
      end
   endtask

   function automatic logic [799:0] exp_pix();
      logic [799:0] v = '0;
      for (int i = 0; i < BP; i++) v[8*i +: 8] = m_img[i];
      return v;
   endfunction

   function automatic logic [799:0] exp_wt();
      logic [799:0] v = '0;
      for (int i = 0; i < BWT; i++) v[8*i +: 8] = m_img[BP+i];
      return v;
   endfunction

   function automatic logic [11:0] exp_stat();
      return {3'(m_st), m_st == 1, (m_st >= 2 && m_st <= 4), (m_st >= 1 && m_st <= 4),
              m_st == 5, m_st == 7, m_res};
   endfunction

   task automatic step();
      @(posedge clk);
      model_step();
      #1;
      chk("status", 800'({state, load_ready, layer_rst_n, busy, done, error, result}), 800'(exp_stat()));
      chk("pixels", 800'(pixels), exp_pix());
      chk("weights", 800'(weights), exp_wt());
      if (tracing && (trace.size() == 0 || trace[$] != state)) trace.push_back(state);
   endtask

   task automatic clear_inputs();
      start = 0; abort = 0; load_valid = 0; load_data = '0;
      l1_done = 0; l2_done = 0; l3_done = 0; result_in = '0;
   endtask

   task automatic do_reset();
      clear_inputs();
      rst_n = 0;
      model_reset();
      repeat (2) @(posedge clk);
      #1 rst_n = 1;
      repeat (3) step();
   endtask

   task automatic load_image(input logic [7:0] b0, input logic [7:0] b98, input bit gaps);
      int acc_cnt = 0;
      for (int cyc = 0; cyc < 8*NB; cyc++) begin
         bit acc;
         if (acc_cnt == NB) break;
         load_valid = gaps ? ((cyc % 2) == 0) : 1'b1;
         load_data  = (acc_cnt == 0) ? b0 : (acc_cnt == BP) ? b98 : 8'($urandom);
         acc = load_valid && load_ready;
         step();
         if (acc) acc_cnt++;
      end
      load_valid = 0;
      chk("beats_accepted", 800'(acc_cnt), 800'(NB));
   endtask

   task automatic start_load();
      start = 1; step(); start = 0;
   endtask

   task automatic run_layer(input int k, input int wait_cyc);
      repeat (wait_cyc) step();
      l1_done = (k == 1); l2_done = (k == 2); l3_done = (k == 3);
      step();
      l1_done = 0; l2_done = 0; l3_done = 0;
   endtask

   typedef struct {
      logic       st, ab, lv;
      logic [7:0] ld;
      logic [2:0] fl;     // {l3,l2,l1}
      logic [2:0] e_st;
      logic [4:0] e_fl;   // {load_ready, layer_rst_n, busy, done, error}
   } vec_t;

   vec_t tbl [10];

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [14:0] tv;
      int          t;
      int          n;

      // Reset values and synchronised release.
      clear_inputs();
      rst_n = 1;
      #2 rst_n = 0;
      @(posedge clk); #3;
      chk("reset_status", 800'({state, load_ready, layer_rst_n, busy, done, error, result}), 800'(0));
      chk("reset_pixels", 800'(pixels), 800'(0));
      chk("reset_weights", 800'(weights), 800'(0));
      start = 1;
      rst_n = 1;
      @(posedge clk); #1;
      chk("sync_edge1_idle", 800'(state), 800'(3'b000));
      repeat (2) @(posedge clk); #1;
      chk("sync_edge3_load", 800'(state), 800'(3'b001));
      do_reset();

      tbl[0] = '{1'b0, 1'b0, 1'b0, 8'h00, 3'b000, 3'd0, 5'b00000};
      tbl[1] = '{1'b1, 1'b1, 1'b0, 8'h00, 3'b000, 3'd0, 5'b00000};
      tbl[2] = '{1'b1, 1'b0, 1'b0, 8'h00, 3'b000, 3'd1, 5'b10100};
      tbl[3] = '{1'b1, 1'b0, 1'b0, 8'h00, 3'b000, 3'd1, 5'b10100};
      tbl[4] = '{1'b0, 1'b0, 1'b1, 8'h11, 3'b000, 3'd1, 5'b10100};
      tbl[5] = '{1'b0, 1'b0, 1'b1, 8'h22, 3'b001, 3'd1, 5'b10100};
      tbl[6] = '{1'b0, 1'b1, 1'b1, 8'h33, 3'b000, 3'd0, 5'b00000};
      tbl[7] = '{1'b0, 1'b0, 1'b0, 8'h00, 3'b111, 3'd0, 5'b00000};
      tbl[8] = '{1'b1, 1'b0, 1'b0, 8'h00, 3'b000, 3'd1, 5'b10100};
      tbl[9] = '{1'b0, 1'b1, 1'b0, 8'h00, 3'b000, 3'd0, 5'b00000};
      for (int i = 0; i < 10; i++) begin
         start = tbl[i].st; abort = tbl[i].ab; load_valid = tbl[i].lv; load_data = tbl[i].ld;
         {l3_done, l2_done, l1_done} = tbl[i].fl;
         step();
         chk($sformatf("vec%0d", i), 800'({state, load_ready, layer_rst_n, busy, done, error}),
             800'({tbl[i].e_st, tbl[i].e_fl}));
      end
      clear_inputs();

      // Full run.
      trace.delete();
      tracing = 1;
      start_load();
      load_image(8'hA5, 8'h3C, 1'b0);
      run_layer(1, 10);
      run_layer(2, 10);
      result_in = 4'd7;
      run_layer(3, 10);
      tracing = 0;
      tv = '0;
      for (int i = 0; i < trace.size() && i < 5; i++) tv[14-3*i -: 3] = trace[i];
      chk("trace_len", 800'(trace.size()), 800'(5));
      chk("trace", 800'(tv), 800'(15'b001_010_011_100_101));
      chk("full_pix0", 800'(pixels[7:0]), 800'(8'hA5));
      chk("full_wt0", 800'(weights[7:0]), 800'(8'h3C));
      chk("full_done", 800'({done, busy, result}), 800'({1'b1, 1'b0, 4'd7}));
      start_load();
      chk("restart_from_done", 800'({state, done}), 800'({3'b001, 1'b0}));
      abort = 1; step(); abort = 0;

      // Backpressure, then abort+start together in LAYER1.
      start_load();
      load_image(8'h01, 8'h02, 1'b1);
      chk("bp_layer1", 800'({state, load_ready}), 800'({3'b010, 1'b0}));
      n = 0;
      load_valid = 1;
      repeat (3) begin
         if (load_valid && load_ready) n++;
         step();
      end
      load_valid = 0;
      chk("bp_no_extra", 800'(n), 800'(0));
      abort = 1; start = 1; step(); abort = 0; start = 0;
      chk("abort_start", 800'({state, busy, layer_rst_n}), 800'({3'b000, 1'b0, 1'b0}));
      step();
      chk("start_ignored", 800'(state), 800'(3'b000));

      // Stale l1_done in LAYER2, then watchdog expiry.
      start_load();
      load_image(8'h10, 8'h20, 1'b0);
      l1_done = 1; step();
      chk("enter_l2", 800'(state), 800'(3'b011));
      t = 0;
      for (int i = 1; i <= TO + 4; i++) begin
         l1_done = (i <= 5);
         step();
         if (i <= 5) chk("stale_l1", 800'(state), 800'(3'b011));
         if (t == 0 && state == 3'b111) t = i;
      end
      l1_done = 0;
      chk("timeout_cycles", 800'(t), 800'(TO));
      chk("error_flags", 800'({state, error, layer_rst_n, busy}), 800'({3'b111, 1'b1, 1'b0, 1'b0}));
      start_load();
      chk("restart_from_error", 800'({state, error}), 800'({3'b001, 1'b0}));

      // Done flag on the last watchdog cycle wins.
      load_image(8'h44, 8'h55, 1'b0);
      repeat (TO - 1) step();
      chk("pre_timeout", 800'(state), 800'(3'b010));
      l1_done = 1; step();
      chk("done_wins", 800'(state), 800'(3'b011));
      repeat (3) step();
      chk("stale_hold", 800'(state), 800'(3'b011));
      l1_done = 0; l2_done = 1; step(); l2_done = 0;
      chk("l2_advance", 800'(state), 800'(3'b100));
      abort = 1; step(); abort = 0;

      // Asynchronous reset in the middle of LOAD.
      start_load();
      for (int i = 0; i < 50; i++) begin
         load_valid = 1; load_data = 8'($urandom); step();
      end
      load_valid = 0;
      #2 rst_n = 0;
      #1;
      chk("async_rst_status", 800'({state, load_ready, layer_rst_n, busy, done, error, result}), 800'(0));
      chk("async_rst_data", 800'({pixels, weights}), 800'(0));
      do_reset();
      start_load();
      load_valid = 1; load_data = 8'h5A; step(); load_valid = 0;
      chk("reload_beat0", 800'(pixels[15:0]), 800'(16'h005A));
      abort = 1; step(); abort = 0;

      // Randomised traffic against the model.
      for (int i = 0; i < 2500; i++) begin
         start      = ($urandom_range(9) == 0);
         abort      = ($urandom_range(59) == 0);
         load_valid = $urandom_range(1) == 1;
         load_data  = 8'($urandom);
         l1_done    = ($urandom_range(39) == 0);
         l2_done    = ($urandom_range(39) == 0);
         l3_done    = ($urandom_range(39) == 0);
         result_in  = 4'($urandom);
         step();
      end
      clear_inputs();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
